// File: rtl/bdi_pkg.sv
// Shared types and constants for the BDI line-fill compressor.
// Optional feature macro used by this slice: BDI_ZERO_BASE_EN.
package bdi_pkg;

  localparam int unsigned LINE_W    = 512;
  localparam int unsigned PAYLOAD_W = 256;

  localparam logic [7:0] BDI_UNCOMP = 8'h00;
  localparam logic [7:0] BDI_ZERO   = 8'h01;
  localparam logic [7:0] BDI_REPEAT = 8'h02;
  localparam logic [7:0] BDI_B4D1   = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ANALYZE,
    ST_HOLD
  } state_t;

  typedef logic [15:0][31:0] line_t;

  // True when a 32-bit value, read as signed, lies in [-128,127].
  function automatic logic fits_s8(input logic [31:0] v);
    return (v[31:7] == '0) || (v[31:7] == '1);
  endfunction

endpackage

// File: rtl/bdi_b4d1_check.sv
// Combinational base4-delta1 fit check for one 16-word line.
// With BDI_ZERO_BASE_EN defined, words that fit against the implicit
// zero base are marked in the mask and take that base in preference.
module bdi_b4d1_check
  import bdi_pkg::*;
(
  input  line_t         line,
  input  logic [31:0]   base,
  output logic          fit,
  output logic [15:0]   mask,
  output logic [127:0]  deltas
);

  logic [15:0][31:0] diff;

  // Per-word difference against the explicit base (mod 2^32).
  always_comb begin
    diff = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      diff[i] = line[i] - base;
    end
  end

  // Every word must fit one of the available bases.
  always_comb begin
    fit    = 1'b1;
    mask   = '0;
    deltas = '0;
    for (int unsigned i = 0; i < 16; i++) begin
`ifdef BDI_ZERO_BASE_EN
      if (fits_s8(line[i])) begin
        mask[i]          = 1'b1;
        deltas[i*8 +: 8] = line[i][7:0];
      end else if (fits_s8(diff[i])) begin
        deltas[i*8 +: 8] = diff[i][7:0];
      end else begin
        fit = 1'b0;
      end
`else
      if (fits_s8(diff[i])) begin
        deltas[i*8 +: 8] = diff[i][7:0];
      end else begin
        fit = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/bdi_line_compressor.sv
// Collects a 16-word line, classifies it as ZERO / REPEAT / B4D1 / UNCOMP
// and holds the registered result until the cache controller takes it.
// Optional feature macro: BDI_ZERO_BASE_EN (implicit zero base + mask).
module bdi_line_compressor
  import bdi_pkg::*;
#(
  parameter int unsigned WORDS  = 16,
  parameter int unsigned WORD_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_W-1:0]         fill_word,
  input  logic                      fill_valid,
  output logic                      fill_ready,
  input  logic                      fill_flush,
  output logic                      line_valid,
  input  logic                      line_ready,
  output logic [7:0]                line_mode,
  output logic [PAYLOAD_W-1:0]      line_payload,
  output logic [15:0]               line_base_mask,
  output logic [WORDS*WORD_W-1:0]   line_raw
);

  state_t                     state_q;
  logic [$clog2(WORDS)-1:0]   cnt_q;
  line_t                      words_q;

  logic [31:0]                base;
  logic                       all_zero;
  logic                       all_rep;
  logic                       chk_fit;
  logic [15:0]                chk_mask;
  logic [127:0]               chk_deltas;
  logic [7:0]                 mode_n;
  logic [PAYLOAD_W-1:0]       payload_n;
  logic [15:0]                mask_n;

  assign fill_ready = (state_q == ST_COLLECT);
  assign line_valid = (state_q == ST_HOLD);

  // Explicit base: first word outside the zero-base range, or word0.
  always_comb begin
    base = '0;
`ifdef BDI_ZERO_BASE_EN
    for (int unsigned i = 16; i > 0; i--) begin
      if (!fits_s8(words_q[i-1])) begin
        base = words_q[i-1];
      end
    end
`else
    base = words_q[0];
`endif
  end

  // Whole-line equality tests for the ZERO and REPEAT encodings.
  always_comb begin
    all_zero = 1'b1;
    all_rep  = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (words_q[i] != '0)         all_zero = 1'b0;
      if (words_q[i] != words_q[0]) all_rep  = 1'b0;
    end
  end

  bdi_b4d1_check u_check (
    .line   (words_q),
    .base   (base),
    .fit    (chk_fit),
    .mask   (chk_mask),
    .deltas (chk_deltas)
  );

  // Priority encode the result and pack the payload.
  always_comb begin
    mode_n    = BDI_UNCOMP;
    payload_n = '0;
    mask_n    = '0;
    if (all_zero) begin
      mode_n = BDI_ZERO;
    end else if (all_rep) begin
      mode_n          = BDI_REPEAT;
      payload_n[31:0] = words_q[0];
    end else if (chk_fit) begin
      mode_n            = BDI_B4D1;
      payload_n[31:0]   = base;
      payload_n[159:32] = chk_deltas;
      mask_n            = chk_mask;
    end
  end

  // FSM and beat counter; flush overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (fill_flush) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE:    state_q <= ST_COLLECT;
        ST_COLLECT: begin
          if (fill_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) state_q <= ST_ANALYZE;
          end
        end
        ST_ANALYZE: state_q <= ST_HOLD;
        ST_HOLD:    if (line_ready) state_q <= ST_COLLECT;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Line storage, written one beat at a time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_q <= '0;
    end else if (!fill_flush && state_q == ST_COLLECT && fill_valid) begin
      words_q[cnt_q] <= fill_word;
    end
  end

  // Result registers, loaded only in ANALYZE; they keep their value otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_mode      <= '0;
      line_payload   <= '0;
      line_base_mask <= '0;
      line_raw       <= '0;
    end else if (!fill_flush && state_q == ST_ANALYZE) begin
      line_mode      <= mode_n;
      line_payload   <= payload_n;
      line_base_mask <= mask_n;
      line_raw       <= words_q;
    end
  end

endmodule

// File: tb/tb_bdi_line_compressor.sv
// Directed self-checking bench for bdi_line_compressor.
module tb_bdi_line_compressor;
  import bdi_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   fill_word;
  logic          fill_valid;
  logic          fill_ready;
  logic          fill_flush;
  logic          line_valid;
  logic          line_ready;
  logic [7:0]    line_mode;
  logic [255:0]  line_payload;
  logic [15:0]   line_base_mask;
  logic [511:0]  line_raw;

  int n_tests = 0;
  int n_fail  = 0;
  int lv_rises = 0;
  logic lv_prev = 1'b0;

  bdi_line_compressor #(.WORDS(16), .WORD_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .fill_word      (fill_word),
    .fill_valid     (fill_valid),
    .fill_ready     (fill_ready),
    .fill_flush     (fill_flush),
    .line_valid     (line_valid),
    .line_ready     (line_ready),
    .line_mode      (line_mode),
    .line_payload   (line_payload),
    .line_base_mask (line_base_mask),
    .line_raw       (line_raw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    lv_prev <= line_valid;
    if (line_valid && !lv_prev) lv_rises <= lv_rises + 1;
  end

  task automatic send_beat(input logic [31:0] w);
    int guard = 0;
    fill_valid = 1'b1;
    fill_word  = w;
    while (!fill_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!fill_ready) begin
      n_tests++; n_fail++;
      $display("FAIL beat_timeout: fill_ready=%0b required 1", fill_ready);
    end
    @(posedge clk); #1;
    fill_valid = 1'b0;
  endtask

  task automatic send_line(input line_t l);
    for (int i = 0; i < 16; i++) send_beat(l[i]);
  endtask

  // Called #1 after the edge that took beat 16.
  task automatic check_result(input string nm, input logic [7:0] m,
                              input logic [255:0] p, input logic [15:0] k,
                              input logic [511:0] raw);
    n_tests++;
    if (line_valid !== 1'b0 || fill_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_analyze: line_valid=%0b fill_ready=%0b required 0 0", nm, line_valid, fill_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (line_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid: got %0b required 1", nm, line_valid);
    end
    n_tests++;
    if (line_mode !== m) begin
      n_fail++;
      $display("FAIL %s_mode: got %h required %h", nm, line_mode, m);
    end
    n_tests++;
    if (line_payload !== p) begin
      n_fail++;
      $display("FAIL %s_payload: got %h required %h", nm, line_payload, p);
    end
    n_tests++;
    if (line_base_mask !== k) begin
      n_fail++;
      $display("FAIL %s_mask: got %h required %h", nm, line_base_mask, k);
    end
    n_tests++;
    if (line_raw !== raw) begin
      n_fail++;
      $display("FAIL %s_raw: got %h required %h", nm, line_raw, raw);
    end
  endtask

  task automatic accept_line(input string nm);
    line_ready = 1'b1;
    @(posedge clk); #1;
    line_ready = 1'b0;
    n_tests++;
    if (line_valid !== 1'b0 || fill_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept: line_valid=%0b fill_ready=%0b required 0 1", nm, line_valid, fill_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; fill_word = '0; fill_valid = 1'b0; fill_flush = 1'b0; line_ready = 1'b0;
    #3;
    n_tests++;
    if ({fill_ready, line_valid, line_mode, line_payload, line_base_mask, line_raw} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b mode=%h mask=%h required all 0",
               fill_ready, line_valid, line_mode, line_base_mask);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (fill_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_ready: got %0b required 0", fill_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (fill_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_ready: got %0b required 1", fill_ready);
    end
  endtask

  task automatic test_zero();
    line_t l = '0;
    send_line(l);
    check_result("zero", 8'h01, '0, '0, l);
    accept_line("zero");
  endtask

  task automatic test_repeat();
    line_t l;
    logic [255:0] p = '0;
    for (int i = 0; i < 16; i++) l[i] = 32'hDEADBEEF;
    p[31:0] = 32'hDEADBEEF;
    send_line(l);
    check_result("repeat", 8'h02, p, '0, l);
    accept_line("repeat");
  endtask

  task automatic test_b4d1_ramp();
    line_t l;
    logic [255:0] p = '0;
    for (int i = 0; i < 16; i++) begin
      l[i] = 32'h1000 + i;
      p[32+8*i +: 8] = i[7:0];
    end
    p[31:0] = 32'h1000;
    send_line(l);
    check_result("ramp", 8'h03, p, '0, l);
    accept_line("ramp");
  endtask

  task automatic test_zero_base();
    line_t l;
    logic [255:0] p = '0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        l[i] = 32'd5;
        p[32+8*i +: 8] = 8'd5;
      end else begin
        l[i] = 32'h80000000 + i;
        p[32+8*i +: 8] = 8'(i - 1);
      end
    end
    p[31:0] = 32'h80000001;
    send_line(l);
`ifdef BDI_ZERO_BASE_EN
    check_result("altbase", 8'h03, p, 16'h5555, l);
`else
    check_result("altbase", 8'h00, '0, '0, l);
`endif
    accept_line("altbase");
  endtask

  task automatic test_uncomp_hold();
    line_t l;
    for (int i = 0; i < 16; i++) l[i] = 32'h9E3779B9 * (i + 1);
    l[5] = 32'h12345678;
    send_line(l);
    check_result("uncomp", 8'h00, '0, '0, l);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (line_valid !== 1'b1 || fill_ready !== 1'b0 || line_mode !== 8'h00 || line_raw !== l) begin
        n_fail++;
        $display("FAIL hold_stable_%0d: valid=%0b ready=%0b mode=%h required 1 0 00 raw_ok=%0b",
                 c, line_valid, fill_ready, line_mode, line_raw === l);
      end
    end
    accept_line("uncomp");
  endtask

  task automatic test_flush();
    line_t l = '0;
    int r0;
    for (int i = 0; i < 7; i++) send_beat(32'h11);
    fill_valid = 1'b1; fill_word = 32'h77; fill_flush = 1'b1;
    @(posedge clk); #1;
    fill_flush = 1'b0; fill_valid = 1'b0;
    r0 = lv_rises;
    send_line(l);
    check_result("flush", 8'h01, '0, '0, l);
    accept_line("flush");
    n_tests++;
    if (lv_rises - r0 !== 1) begin
      n_fail++;
      $display("FAIL flush_count: got %0d line_valid pulses required 1", lv_rises - r0);
    end
  endtask

  task automatic test_reset_in_hold();
    line_t l;
    logic [255:0] p = '0;
    for (int i = 0; i < 16; i++) l[i] = 32'hDEADBEEF;
    p[31:0] = 32'hDEADBEEF;
    send_line(l);
    check_result("rsthold", 8'h02, p, '0, l);
    rst = 1'b0;
    #2;
    n_tests++;
    if ({fill_ready, line_valid, line_mode, line_payload, line_base_mask, line_raw} !== '0) begin
      n_fail++;
      $display("FAIL rsthold_outputs: ready=%0b valid=%0b mode=%h payload_lo=%h required all 0",
               fill_ready, line_valid, line_mode, line_payload[31:0]);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (fill_ready !== 1'b1 || line_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsthold_restart: ready=%0b valid=%0b required 1 0", fill_ready, line_valid);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_repeat();
    test_b4d1_ramp();
    test_zero_base();
    test_uncomp_hold();
    test_flush();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bdi_line_compressor.md
# bdi_line_compressor

Line-fill compressor placed between main-memory read data and the cache write port. It collects the sixteen 32-bit words of a 512-bit line from the memory read stream. It then classifies the line under Base-Delta-Immediate with a 4-byte base: all-zero, repeated word, base4-delta1, or uncompressed. It presents the compressed payload, mode and per-word base mask to the cache controller for the cache-line write.

## Interface
Parameters:
- WORDS, 16, words per line; fixed by the line format.
- WORD_W, 32, word width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- fill_word  in  32  memory read word, line order word 0 first.
- fill_valid  in  1  fill_word is valid.
- fill_ready  out  1  block accepts a word; a beat transfers when fill_valid & fill_ready.
- fill_flush  in  1  synchronous abort; drops any partial or held line.
- line_valid  out  1  compressed line result is available.
- line_ready  in  1  consumer accepts the result; transfer when line_valid & line_ready.
- line_mode  out  8  encoding: 8'h00 UNCOMP, 8'h01 ZERO, 8'h02 REPEAT, 8'h03 B4D1.
- line_payload  out  256  compressed payload; zero when UNCOMP.
- line_base_mask  out  16  bit i=1: word i is encoded against the implicit zero base.
- line_raw  out  512  uncompressed line, word i at [32i+31:32i].

## Operation
- States: IDLE, COLLECT, ANALYZE, HOLD.
  - IDLE: entered only from reset; goes to COLLECT on the next edge.
- COLLECT:
  - fill_ready=1.
  - Each beat writes word[cnt], then cnt+1. cnt is 4 bits.
  - The beat with cnt==15 wraps cnt to 0 and moves to ANALYZE.
- ANALYZE (one cycle):
  - fill_ready=0.
  - Classification priority: ZERO, then REPEAT, then B4D1, then UNCOMP.
    - ZERO: all words are 0.
    - REPEAT: all words equal word0.
    - B4D1: a delta fits if (w - base) mod 2^32, interpreted signed, lies in [-128,127].
  - B4D1 base selection:
    - The base is the first word whose value does not fit as a delta from 0.
    - If no such word exists, ZERO or REPEAT has already matched, or B4D1 applies with base 0.
    - B4D1 holds if every word fits against either base 0 or the explicit base.
    - Zero base is preferred when a word fits both.
  - Results are registered into the outputs; the state moves to HOLD.
- HOLD:
  - line_valid=1; all line_* outputs are stable.
  - On line_valid & line_ready: line_valid=0 and the state returns to COLLECT.
- Payload layout (unused bits are 0):
  - ZERO: all bits 0.
  - REPEAT: [31:0]=word0.
  - B4D1: [31:0]=base; [32+8i+7:32+8i]=delta of word i. The delta is the word's low 8 bits when its mask bit is set, otherwise (w-base)[7:0].
  - UNCOMP: payload 0, mask 0; the consumer uses line_raw.
- line_base_mask is 0 for ZERO, REPEAT and UNCOMP.
- fill_flush has priority over all other events in every state:
  - next state COLLECT, cnt=0, line_valid=0, outputs retain their values.
  - A beat presented in the same cycle is dropped.
- fill_valid is ignored outside COLLECT; line_ready is ignored outside HOLD.

## Timing
- Reset values: fill_ready=0, line_valid=0, line_mode=0, line_payload=0, line_base_mask=0, line_raw=0, cnt=0, state IDLE.
- fill_ready first rises one edge after reset release, when IDLE moves to COLLECT.
- 16th beat accepted at edge N: ANALYZE spans cycle N→N+1, and line_valid=1 from edge N+1.
- Minimum period with no backpressure: 18 cycles per line (16 beats, ANALYZE, HOLD/transfer).
- Reset asserted mid-line: state clears immediately; the partial line is lost.

## Configuration
- BDI_ZERO_BASE_EN defined: implicit zero base is active, and line_base_mask is computed as in Operation.
- Not defined:
  - The explicit base is always word0; line_base_mask is tied to 0.
  - B4D1 requires every word to fit against word0.
  - ZERO and REPEAT detection are unchanged.

## Structure
- Package bdi_pkg:
  - mode constants (BDI_UNCOMP, BDI_ZERO, BDI_REPEAT, BDI_B4D1)
  - LINE_W=512, PAYLOAD_W=256
  - state enum typedef
  - line array typedef logic [15:0][31:0]
- One sub-module, bdi_b4d1_check: combinational. Inputs are the line array and the base. Outputs are fit flag, mask and packed deltas. It is instantiated once in ANALYZE.
- Line storage, counter and FSM live in bdi_line_compressor.

## Test plan
- All words 0 → mode 8'h01, payload 0, mask 0, line_valid at edge N+1.
- All words 32'hDEADBEEF → mode 8'h02, payload[31:0]=32'hDEADBEEF, rest 0.
- Words 32'h1000+i → mode 8'h03, base 32'h1000, delta i = i; word 0 equals base and falls outside the zero base, so mask=0.
- Words alternate 5 and 32'h80000000+i, with BDI_ZERO_BASE_EN defined → mode 8'h03, mask=16'h5555, base=32'h80000001. Without the macro the same line → mode 8'h00.
- Word5=32'h12345678 and the other words pseudo-random (no fit) → mode 8'h00. line_raw matches input; line_ready held low 10 cycles → outputs stable and fill_ready=0 throughout.
- fill_flush after 7 beats, then a full ZERO line → only one line_valid, mode 8'h01; rst pulsed in HOLD → all outputs return to reset values.
